prog_mod_counter: RTL and testbench

- Parametrised successor to the fixed-modulus `counter` block: binary counter with run-time limit, up/down direction, parallel load, and three terminal behaviours (wrap, saturate, one-shot).
- Issues a single-cycle `done` pulse and a `tc` level.
- Used as a generic timing/sequence counter by the project's FSMs, replacing per-use fixed counters.

---
 rtl/prog_mod_counter.sv | 150 +++++++++++++++
 tb/tb_prog_mod_counter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/prog_mod_counter.sv
// ---------------------------------------------------------------------------
// prog_mod_counter
//   Programmable-modulus binary counter for use as a generic timing/sequence
//   counter. It has a run-time limit register, up/down counting, a parallel
//   load, and three terminal behaviours: wrap, saturate and one-shot.
//
// Parameters
//   WIDTH     width of count / load_val / limit
//   MAX       reset value of the limit register (0 .. 2^WIDTH-1)
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   en        count enable, one step per cycle
//   up        1 = increment toward limit, 0 = decrement toward 0
//   mode      00 wrap, 01 saturate, 10 one-shot, 11 wrap
//   load      parallel load strobe (clamped to the effective limit)
//   load_val  value to load
//   cfg_we    limit register write strobe
//   limit     new limit value
//   count     registered count
//   tc        combinational: count is at the terminal value for current `up`
//   done      registered one-cycle pulse: an enabled step landed on terminal
//   running   1 in RUN, 0 in HALT (one-shot finished)
// ---------------------------------------------------------------------------
module prog_mod_counter #(
  parameter int WIDTH = 3,
  parameter int MAX   = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             cfg_we,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             done,
  output logic             running
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;

  localparam logic [WIDTH-1:0] ZERO  = '0;
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             done_q,  done_d;
  logic [0:0]       state_q, state_d;

  logic             is_wrap;
  logic             is_oneshot;
  logic [WIDTH-1:0] lim_eff;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] cnt_inc;
  logic [WIDTH-1:0] cnt_dec;
  logic [WIDTH-1:0] step_cnt;
  logic             step_land;

  // Mode 11 is an alias of wrap, so decode wrap as "neither saturate nor
  // one-shot".
  assign is_wrap    = (mode != MODE_SAT) && (mode != MODE_ONESHOT);
  assign is_oneshot = (mode == MODE_ONESHOT);

  // A load in the same cycle as a limit write clamps against the new limit.
  assign lim_eff      = cfg_we ? limit : limit_q;
  assign load_clamped = (load_val > lim_eff) ? lim_eff : load_val;

  assign cnt_inc = count_q + ONE;
  assign cnt_dec = count_q - ONE;

  // Next count for an enabled step, and whether that step lands on the
  // terminal value from a different value.
  always_comb begin
    step_cnt  = count_q;
    step_land = 1'b0;
    if (count_q > limit_q) begin
      // Limit was lowered below the count: snap down to the limit. This is
      // a terminal landing only when counting up (terminal = limit).
      step_cnt  = limit_q;
      step_land = up;
    end else if (up) begin
      if (count_q != limit_q) begin
        step_cnt  = cnt_inc;
        step_land = (cnt_inc == limit_q);
      end else if (is_wrap) begin
        // With limit 0 the wrap target is the terminal itself, so every
        // enabled step counts as a landing.
        step_cnt  = ZERO;
        step_land = (limit_q == ZERO);
      end
    end else begin
      if (count_q != ZERO) begin
        step_cnt  = cnt_dec;
        step_land = (cnt_dec == ZERO);
      end else if (is_wrap) begin
        step_cnt  = limit_q;
        step_land = (limit_q == ZERO);
      end
    end
  end

  // Priority: load over enabled step. The limit write is independent.
  always_comb begin
    count_d = count_q;
    limit_d = limit_q;
    state_d = state_q;
    done_d  = 1'b0;
    if (cfg_we) limit_d = limit;
    if (load) begin
      count_d = load_clamped;
      state_d = ST_RUN;
    end else if (en && (state_q == ST_RUN)) begin
      count_d = step_cnt;
      done_d  = step_land;
      if (step_land && is_oneshot) state_d = ST_HALT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= ZERO;
      limit_q <= MAX_V;
      done_q  <= 1'b0;
      state_q <= ST_RUN;
    end else begin
      count_q <= count_d;
      limit_q <= limit_d;
      done_q  <= done_d;
      state_q <= state_d;
    end
  end

  assign count   = count_q;
  assign done    = done_q;
  assign running = (state_q == ST_RUN);
  // Terminal tracks the live `up` input so a direction change re-decodes
  // immediately.
  assign tc      = (count_q == (up ? limit_q : ZERO));

endmodule

// File: tb/tb_prog_mod_counter.sv
// ---------------------------------------------------------------------------
// tb_prog_mod_counter
//   Directed-vector bench for prog_mod_counter (WIDTH=3, MAX=6). Each vector
//   sets the inputs for one clock edge and queues the hand-computed outputs
//   expected after that edge; a monitor pops and compares at the falling
//   edge.
// ---------------------------------------------------------------------------
module tb_prog_mod_counter;

  logic       clk = 1'b0;
  logic       rst, en, up, load, cfg_we;
  logic [1:0] mode;
  logic [2:0] load_val, limit;
  logic [2:0] count;
  logic       tc, done, running;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [2:0] cnt;
    logic       tc;
    logic       done;
    logic       run;
  } exp_t;

  exp_t exp_q[$];

  prog_mod_counter #(.WIDTH(3), .MAX(6)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .mode(mode),
    .load(load), .load_val(load_val), .cfg_we(cfg_we), .limit(limit),
    .count(count), .tc(tc), .done(done), .running(running)
  );

  always #5 clk = ~clk;

  // Inputs change just after the falling edge, so the value of `up` seen by
  // tc at the next falling edge is the one that went with this vector.
  task automatic v(input string tag, input logic r, input logic e,
                   input logic u, input logic [1:0] m, input logic ld,
                   input logic [2:0] lv, input logic we, input logic [2:0] lim,
                   input logic [2:0] ec, input logic etc, input logic ed,
                   input logic erun);
    exp_t x;
    @(negedge clk);
    #1;
    rst = r; en = e; up = u; mode = m; load = ld; load_val = lv;
    cfg_we = we; limit = lim;
    @(posedge clk);
    x.tag = tag; x.cnt = ec; x.tc = etc; x.done = ed; x.run = erun;
    exp_q.push_back(x);
  endtask

  // Monitor: every cycle the counter presents a result.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({count, tc, done, running} !== {e.cnt, e.tc, e.done, e.run}) begin
          errors++;
          $display("FAIL %s: got count=%0d tc=%0b done=%0b running=%0b, want count=%0d tc=%0b done=%0b running=%0b",
                   e.tag, count, tc, done, running, e.cnt, e.tc, e.done, e.run);
        end
      end
    end
  end

  initial begin : stim
    int waited;
    rst = 1'b1; en = 1'b0; up = 1'b1; mode = 2'b00; load = 1'b0;
    load_val = '0; cfg_we = 1'b0; limit = '0;

    // Reset held 5 cycles
    for (int i = 0; i < 5; i++) v("reset", 1,0,1,2'b00,0,0,0,0, 0,0,0,1);

    // Wrap up-count at limit 6
    v("wrap1", 0,1,1,2'b00,0,0,0,0, 1,0,0,1);
    v("wrap2", 0,1,1,2'b00,0,0,0,0, 2,0,0,1);
    v("wrap3", 0,1,1,2'b00,0,0,0,0, 3,0,0,1);
    v("wrap4", 0,1,1,2'b00,0,0,0,0, 4,0,0,1);
    v("wrap5", 0,1,1,2'b00,0,0,0,0, 5,0,0,1);
    v("wrap6", 0,1,1,2'b00,0,0,0,0, 6,1,1,1);
    v("wrap0", 0,1,1,2'b00,0,0,0,0, 0,0,0,1);
    v("wrap1b",0,1,1,2'b00,0,0,0,0, 1,0,0,1);
    v("wrap2b",0,1,1,2'b00,0,0,0,0, 2,0,0,1);
    v("wrap3b",0,1,1,2'b00,0,0,0,0, 3,0,0,1);

    // Enable gating at count 3
    for (int i = 0; i < 5; i++) v("en_hold", 0,0,1,2'b00,0,0,0,0, 3,0,0,1);
    v("en_resume", 0,1,1,2'b00,0,0,0,0, 4,0,0,1);

    // Saturate, counting down from a load of 4
    v("sat_load", 0,1,0,2'b01,1,4,0,0, 4,0,0,1);
    v("sat_d3",   0,1,0,2'b01,0,0,0,0, 3,0,0,1);
    v("sat_d2",   0,1,0,2'b01,0,0,0,0, 2,0,0,1);
    v("sat_d1",   0,1,0,2'b01,0,0,0,0, 1,0,0,1);
    v("sat_d0",   0,1,0,2'b01,0,0,0,0, 0,1,1,1);
    v("sat_h0a",  0,1,0,2'b01,0,0,0,0, 0,1,0,1);
    v("sat_h0b",  0,1,0,2'b01,0,0,0,0, 0,1,0,1);
    // Then saturate counting up
    v("sat_u1",   0,1,1,2'b01,0,0,0,0, 1,0,0,1);
    v("sat_u2",   0,1,1,2'b01,0,0,0,0, 2,0,0,1);
    v("sat_u3",   0,1,1,2'b01,0,0,0,0, 3,0,0,1);
    v("sat_u4",   0,1,1,2'b01,0,0,0,0, 4,0,0,1);
    v("sat_u5",   0,1,1,2'b01,0,0,0,0, 5,0,0,1);
    v("sat_u6",   0,1,1,2'b01,0,0,0,0, 6,1,1,1);
    v("sat_h6a",  0,1,1,2'b01,0,0,0,0, 6,1,0,1);
    v("sat_h6b",  0,1,1,2'b01,0,0,0,0, 6,1,0,1);

    // One-shot from a load of 2
    v("os_load",  0,1,1,2'b10,1,2,0,0, 2,0,0,1);
    v("os_3",     0,1,1,2'b10,0,0,0,0, 3,0,0,1);
    v("os_4",     0,1,1,2'b10,0,0,0,0, 4,0,0,1);
    v("os_5",     0,1,1,2'b10,0,0,0,0, 5,0,0,1);
    v("os_6",     0,1,1,2'b10,0,0,0,0, 6,1,1,0);
    v("os_halt1", 0,1,1,2'b10,0,0,0,0, 6,1,0,0);
    v("os_halt2", 0,1,1,2'b10,0,0,0,0, 6,1,0,0);
    v("os_reload",0,1,1,2'b10,1,0,0,0, 0,0,0,1);
    v("os_r1",    0,1,1,2'b10,0,0,0,0, 1,0,0,1);
    v("os_r2",    0,1,1,2'b10,0,0,0,0, 2,0,0,1);

    // Lower the limit below the count
    v("lim_3",    0,1,1,2'b00,0,0,0,0, 3,0,0,1);
    v("lim_4",    0,1,1,2'b00,0,0,0,0, 4,0,0,1);
    v("lim_5",    0,1,1,2'b00,0,0,0,0, 5,0,0,1);
    v("lim_wr3",  0,0,1,2'b00,0,0,1,3, 5,0,0,1);
    v("lim_snap", 0,1,1,2'b00,0,0,0,0, 3,1,1,1);
    v("lim_wrap", 0,1,1,2'b00,0,0,0,0, 0,0,0,1);
    v("ld_we",    0,1,1,2'b00,1,7,1,4, 4,1,0,1);
    v("ld_we_w0", 0,1,1,2'b00,0,0,0,0, 0,0,0,1);
    v("ld_we_1",  0,1,1,2'b00,0,0,0,0, 1,0,0,1);

    // Limit 0 in wrap: every enabled step is a landing
    v("l0_wr",    0,0,1,2'b00,0,0,1,0, 1,0,0,1);
    v("l0_snap",  0,1,1,2'b00,0,0,0,0, 0,1,1,1);
    v("l0_up",    0,1,1,2'b00,0,0,0,0, 0,1,1,1);
    v("l0_dn",    0,1,0,2'b00,0,0,0,0, 0,1,1,1);

    // Down wrap at limit 6
    v("dw_load",  0,0,0,2'b00,1,1,1,6, 1,0,0,1);
    v("dw_0",     0,1,0,2'b00,0,0,0,0, 0,1,1,1);
    v("dw_wrap",  0,1,0,2'b00,0,0,0,0, 6,0,0,1);

    // Halt, mode change while halted, then reset with a pending limit write
    v("h_load",   0,0,1,2'b10,1,5,0,0, 5,0,0,1);
    v("h_6",      0,1,1,2'b10,0,0,0,0, 6,1,1,0);
    v("h_stay",   0,1,1,2'b10,0,0,0,0, 6,1,0,0);
    v("h_mode",   0,1,1,2'b00,0,0,0,0, 6,1,0,0);
    v("h_rst",    1,1,1,2'b00,0,0,1,2, 0,0,0,1);
    // Limit must still be 6 after the ignored write
    v("pr_1",     0,1,1,2'b00,0,0,0,0, 1,0,0,1);
    v("pr_2",     0,1,1,2'b00,0,0,0,0, 2,0,0,1);
    v("pr_3",     0,1,1,2'b00,0,0,0,0, 3,0,0,1);
    v("pr_4",     0,1,1,2'b00,0,0,0,0, 4,0,0,1);
    v("pr_5",     0,1,1,2'b00,0,0,0,0, 5,0,0,1);
    v("pr_6",     0,1,1,2'b00,0,0,0,0, 6,1,1,1);
    v("pr_0",     0,1,1,2'b00,0,0,0,0, 0,0,0,1);

    // Drain the scoreboard, bounded
    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expected results never compared, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
